// File: rtl/seq_pattern_ctrl_pkg.sv
// rtl/seq_pattern_ctrl_pkg.sv - shared state encodings and helpers for the pattern controller
package seq_pattern_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_DETECT = 3'b001,
        S_PROG   = 3'b010,
        S_COMMIT = 3'b100
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/seq_pattern_ctrl_key_debounce.sv
// rtl/seq_pattern_ctrl_key_debounce.sv - key synchroniser, stability counter and press pulse
module key_debounce #(
    parameter logic [19:0] DEBOUNCE_CYC = 20'd1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_p
);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        stable_q, stable_d;
    logic        stable_dly_q, stable_dly_d;
    logic        key_p_q, key_p_d;
    logic [19:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            key_p_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            key_p_q      <= key_p_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        sync1_d      = key_raw;
        sync2_d      = sync1_q;
        stable_d     = stable_q;
        cnt_d        = cnt_q;
        stable_dly_d = stable_q;
        // Any return to the accepted level restarts the stability window
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEBOUNCE_CYC - 20'd1) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 20'd1;
        end
        key_p_d = stable_q & ~stable_dly_q;
    end

    assign key_p = key_p_q;

endmodule

// File: rtl/seq_pattern_ctrl.sv
// rtl/seq_pattern_ctrl.sv - programmable serial pattern detector with debounced key front end
module seq_pattern_ctrl
    import seq_pattern_ctrl_pkg::*;
#(
    parameter int                  PAT_LEN      = 4,
    parameter logic [PAT_LEN-1:0]  PAT_DEFAULT  = 4'b1101,
    parameter logic [19:0]         DEBOUNCE_CYC = 20'd1000000,
    parameter logic [23:0]         LED_HOLD     = 24'd5000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_raw,
    input  logic               sw,
    input  logic               prog_req,
    output logic               led,
    output logic [7:0]         match_cnt,
    output logic [STATE_W-1:0] state_out,
    output logic [PAT_LEN-1:0] pat_out,
    output logic               key_p
);

    localparam logic [3:0] PAT_LEN_C = 4'(PAT_LEN);

    state_e             state_q, state_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [PAT_LEN-1:0] shadow_q, shadow_d;
    logic [3:0]         hist_cnt_q, hist_cnt_d;
    logic [3:0]         prog_cnt_q, prog_cnt_d;
    logic               led_q, led_d;
    logic [23:0]        timer_q, timer_d;
    logic [7:0]         match_cnt_q, match_cnt_d;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_debounce (
        .clk     (clk),
        .rst     (rst),
        .key_raw (key_raw),
        .key_p   (key_p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_DETECT;
            hist_q      <= '0;
            pat_q       <= PAT_DEFAULT;
            shadow_q    <= '0;
            hist_cnt_q  <= '0;
            prog_cnt_q  <= '0;
            led_q       <= 1'b0;
            timer_q     <= '0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            pat_q       <= pat_d;
            shadow_q    <= shadow_d;
            hist_cnt_q  <= hist_cnt_d;
            prog_cnt_q  <= prog_cnt_d;
            led_q       <= led_d;
            timer_q     <= timer_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        pat_d       = pat_q;
        shadow_d    = shadow_q;
        hist_cnt_d  = hist_cnt_q;
        prog_cnt_d  = prog_cnt_q;
        led_d       = led_q;
        timer_d     = timer_q;
        match_cnt_d = match_cnt_q;

        if (led_q) begin
            if (timer_q == 24'd0) led_d = 1'b0;
            else                  timer_d = timer_q - 24'd1;
        end

        case (state_q)
            S_DETECT: begin
                // Entering programming mode swallows a same-cycle press
                if (prog_req) begin
                    state_d    = S_PROG;
                    prog_cnt_d = '0;
                    led_d      = 1'b0;
                end else if (key_p) begin
                    hist_d = {hist_q[PAT_LEN-2:0], sw};
                    if (hist_cnt_q != PAT_LEN_C) hist_cnt_d = hist_cnt_q + 4'd1;
                    if (hist_d == pat_q && hist_cnt_d == PAT_LEN_C) begin
                        led_d       = 1'b1;
                        timer_d     = LED_HOLD - 24'd1;
                        match_cnt_d = sat_inc8(match_cnt_q);
                    end
                end
            end
            S_PROG: begin
                led_d = 1'b0;
                if (!prog_req) begin
                    state_d = S_DETECT;
                end else if (key_p) begin
                    shadow_d   = {shadow_q[PAT_LEN-2:0], sw};
                    prog_cnt_d = prog_cnt_q + 4'd1;
                    if (prog_cnt_d == PAT_LEN_C) state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                led_d      = 1'b0;
                pat_d      = shadow_q;
                hist_d     = '0;
                hist_cnt_d = '0;
                state_d    = S_DETECT;
            end
            default: begin
                led_d   = 1'b0;
                state_d = S_DETECT;
            end
        endcase
    end

    always_comb begin
        led       = led_q & (state_q == S_DETECT);
        match_cnt = match_cnt_q;
        state_out = state_q;
        pat_out   = pat_q;
    end

endmodule

// File: tb/tb_seq_pattern_ctrl.sv
// tb/tb_seq_pattern_ctrl.sv - directed self-checking bench for seq_pattern_ctrl
module tb_seq_pattern_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_raw = 1'b0;
    logic       sw = 1'b0;
    logic       prog_req = 1'b0;
    logic       led;
    logic [7:0] match_cnt;
    logic [2:0] state_out;
    logic [3:0] pat_out;
    logic       key_p;

    int total = 0;
    int bad = 0;
    int kp_count = 0;
    int exp_cnt;

    seq_pattern_ctrl #(
        .PAT_LEN      (4),
        .PAT_DEFAULT  (4'b1101),
        .DEBOUNCE_CYC (20'd4),
        .LED_HOLD     (24'd8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_raw   (key_raw),
        .sw        (sw),
        .prog_req  (prog_req),
        .led       (led),
        .match_cnt (match_cnt),
        .state_out (state_out),
        .pat_out   (pat_out),
        .key_p     (key_p)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (key_p) kp_count++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Returns one cycle after key_p, when its effect is visible
    task automatic press(input logic b);
        sw = b;
        key_raw = 1'b1;
        repeat (8) step();
    endtask

    task automatic release_key();
        key_raw = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        repeat (3) step();
        chk("rst_led", led, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_state", state_out, 3'b001);
        chk("rst_pat", pat_out, 4'b1101);
        chk("rst_keyp", key_p, 0);
        rst = 1'b0;
        step();

        // 1: bounce then hold
        for (int s = 0; s < 4; s++) begin
            key_raw = (s % 2 == 0);
            repeat (2) step();
        end
        key_raw = 1'b1;
        repeat (6) step();
        chk("db_before", key_p, 0);
        step();
        chk("db_pulse", key_p, 1);
        step();
        chk("db_after", key_p, 0);
        release_key();
        repeat (4) step();
        chk("db_count", kp_count, 1);

        // 2: default pattern, hist now holds one 0
        press(1); release_key();
        press(1); release_key();
        press(0); release_key();
        press(1);
        chk("m1_led", led, 1);
        chk("m1_cnt", match_cnt, 1);
        for (int i = 0; i < 7; i++) step();
        chk("hold_last", led, 1);
        step();
        chk("hold_off", led, 0);
        release_key();
        press(1); release_key();
        press(0);
        chk("ov_noled", led, 0);
        release_key();
        press(1);
        chk("ov_led", led, 1);
        chk("ov_cnt", match_cnt, 2);
        release_key();

        // 3: program 0110
        prog_req = 1'b1;
        step();
        chk("p_state", state_out, 3'b010);
        chk("p_led", led, 0);
        press(0); release_key();
        press(1); release_key();
        press(1); release_key();
        press(0);
        chk("p_commit", state_out, 3'b100);
        prog_req = 1'b0;
        step();
        chk("p_detect", state_out, 3'b001);
        chk("p_pat", pat_out, 4'b0110);
        release_key();
        press(1); release_key();
        press(1); release_key();
        press(0); release_key();
        press(1);
        chk("old_nomatch", led, 0);
        chk("old_cnt", match_cnt, 2);
        release_key();
        press(0); release_key();
        press(1); release_key();
        press(1); release_key();
        press(0);
        chk("new_led", led, 1);
        chk("new_cnt", match_cnt, 3);
        release_key();

        // 4: abort after two bits; hist (0110) must survive
        prog_req = 1'b1;
        step();
        chk("ab_prog", state_out, 3'b010);
        press(1); release_key();
        press(1); release_key();
        prog_req = 1'b0;
        step();
        chk("ab_state", state_out, 3'b001);
        chk("ab_pat", pat_out, 4'b0110);
        press(1); release_key();
        press(1); release_key();
        press(0);
        chk("ab_hist_led", led, 1);
        chk("ab_hist_cnt", match_cnt, 4);
        release_key();

        // 5: program 1111, then saturate the counter
        prog_req = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            press(1); release_key();
        end
        press(1);
        prog_req = 1'b0;
        step();
        chk("s_pat", pat_out, 4'b1111);
        release_key();
        exp_cnt = 4;
        for (int i = 0; i < 255; i++) begin
            press(1);
            if (i >= 3 && exp_cnt < 255) exp_cnt++;
            chk($sformatf("sat_%0d", i), match_cnt, exp_cnt);
            if (i < 254) release_key();
        end
        chk("sat_final", match_cnt, 255);
        step();
        chk("pre_rst_led", led, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_led", led, 0);
        chk("ar_cnt", match_cnt, 0);
        chk("ar_pat", pat_out, 4'b1101);
        chk("ar_state", state_out, 3'b001);
        key_raw = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
